fpnew_opgroup_out_buffer: RTL and testbench
===========================================

// Module: fpnew_opgroup_out_buffer
// PURPOSE
// - Output-side buffer placed directly downstream of an opgroup block; feeds the top-level opgroup arbiter.
// - Stores up to Depth completed results (result, status, ext bit, tag) in order, decoupling slice backpressure.
// - Accumulates sticky IEEE status flags (fflags) over all retired results.
// PARAMETERS
// - Width    32     result datapath width in bits
// - Depth    2      buffer entries; any integer >= 1 (not restricted to powers of two)
// - TagType  logic  type carried alongside each result, returned unmodified
// PORTS
// - clk_i            in   1       clock
// - rst_i            in   1       reset, synchronous, active-high
// - in_valid_i       in   1       upstream result valid
// - in_ready_o       out  1       buffer can accept an entry
// - result_i         in   Width   result from opgroup block
// - status_i         in   5       fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
// - extension_bit_i  in   1       NaN-boxing extension bit
// - tag_i            in   TagType operation tag
// - flush_i          in   1       drop all buffered entries
// - out_valid_o      out  1       head entry valid
// - out_ready_i      in   1       downstream accepts head entry
// - result_o         out  Width   head result
// - status_o         out  5       head status
// - extension_bit_o  out  1       head extension bit
// - tag_o            out  TagType head tag
// - fflags_o         out  5       sticky OR of status over retired entries
// - fflags_clr_i     in   1       clear fflags_o
// - busy_o           out  1       at least one entry held
// BEHAVIOUR
// - Reset (rst_i high at clk edge):
//   - rd/wr pointers and count cleared to 0; fflags_o cleared to 0.
//   - out_valid_o = 0 and busy_o = 0 from the next cycle.
//   - in_ready_o = 0 while rst_i is high; otherwise in_ready_o = (count != Depth).
// - Push: in_valid_i & in_ready_o; entry is written at wr_ptr.
// - Pop: out_valid_o & out_ready_i; rd_ptr advances.
// - Latency: an entry pushed in cycle N is presented on the outputs in cycle N+1; there is no fall-through.
// - in_ready_o depends only on state, with no combinational path from out_ready_i.
//   - When full, a same-cycle pop does not enable a push; the push is accepted the next cycle.
// - Push and pop in the same cycle (0 < count < Depth): count is unchanged and both pointers advance.
// - Pointers wrap from Depth-1 to 0. count is $clog2(Depth+1) bits wide and saturates by construction; no overflow.
// - Empty: out_valid_o = 0. Outputs in this state are don't care (fpnew_pkg::DONT_CARE), and the bench does not check them.
// - Handshake rules: once out_valid_o is asserted, the head entry and out_valid_o stay stable until popped or flushed.
// - Flush (flush_i high):
//   - count and pointers go to 0 next cycle.
//   - A push in the same cycle is discarded.
//   - A pop in the same cycle is still a retirement and updates fflags.
//   - fflags_o itself is not cleared by flush.
// - fflags update: next = (fflags_clr_i ? 0 : fflags_o) | (pop ? status_o : 0).
//   - Clear and pop in the same cycle: the result is the popped status.
// - busy_o = (count != 0), registered-state derived.
// - Reset asserted mid-operation: all entries are lost; no output handshake completes in that cycle.
// STRUCTURE
// - status_t and DONT_CARE come from fpnew_pkg; nothing new is added to the package.
// - Local packed typedef output_t {result, status, ext_bit, tag}, because it depends on Width and TagType.
// - Storage is an output_t array [Depth]. Single module with no sub-module; control is inline pointer/count logic.
// TESTING
// - Reset then idle -> in_ready_o=1, out_valid_o=0, busy_o=0, fflags_o=5'b0.
// - Depth=2: push A (tag 1), B (tag 2) back to back with out_ready_i=0
//   -> in_ready_o=0 after B; out_valid_o=1, tag_o=1.
//   Then out_ready_i=1 for 2 cycles -> tags 1 then 2 in order; busy_o=0 afterwards.
// - Full, out_ready_i=1 and in_valid_i=1 in the same cycle -> pop only that cycle; push accepted the following cycle.
// - Pop status 5'b00001, then 5'b10000 -> fflags_o=5'b10001.
//   fflags_clr_i together with a pop of 5'b00100 -> fflags_o=5'b00100.
// - Two entries held, flush_i with in_valid_i=1 -> next cycle count=0, out_valid_o=0, pushed entry absent.
// - Depth=3, 10 random push/pop cycles spanning wrap-around -> output order matches a scoreboard.
//   Also: rst_i mid-stream -> empty buffer and fflags_o=0.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPnew definitions used by the opgroup output buffer: the IEEE status
// flag bundle and the fill value driven on outputs that carry no meaning.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  localparam logic DONT_CARE = 1'b1;

endpackage

// File: rtl/fpnew_opgroup_out_buffer_if.sv
// Signal bundle around the opgroup output buffer. The master side is the
// opgroup block plus arbiter environment; the slave side is the buffer itself.
interface fpnew_opgroup_out_buffer_if #(
  parameter int unsigned Width   = 32,
  parameter type         TagType = logic
) ();
  import fpnew_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_result;
  status_t          in_status;
  logic             in_ext_bit;
  TagType           in_tag;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_result;
  status_t          out_status;
  logic             out_ext_bit;
  TagType           out_tag;

  status_t          fflags;
  logic             fflags_clr;
  logic             busy;

  modport master (
    output in_valid, in_result, in_status, in_ext_bit, in_tag, flush,
    output out_ready, fflags_clr,
    input  in_ready, out_valid, out_result, out_status, out_ext_bit, out_tag,
    input  fflags, busy
  );

  modport slave (
    input  in_valid, in_result, in_status, in_ext_bit, in_tag, flush,
    input  out_ready, fflags_clr,
    output in_ready, out_valid, out_result, out_status, out_ext_bit, out_tag,
    output fflags, busy
  );

endinterface

// File: rtl/fpnew_opgroup_out_buffer.sv
// In-order result buffer between an FPU opgroup block and the opgroup arbiter.
// Holds up to Depth results and keeps sticky IEEE flags of everything retired.
module fpnew_opgroup_out_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 2,
  parameter type         TagType = logic
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] result_i,
  input  status_t          status_i,
  input  logic             extension_bit_i,
  input  TagType           tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output status_t          status_o,
  output logic             extension_bit_o,
  output TagType           tag_o,
  output status_t          fflags_o,
  input  logic             fflags_clr_i,
  output logic             busy_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
    logic             ext_bit;
    TagType           tag;
  } output_t;

  output_t             mem_q [Depth];
  output_t             wr_entry;
  output_t             head;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  status_t             fflags_q, fflags_d;
  logic                push, pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  // Ready is purely state-derived: a pop never frees a slot in the same cycle.
  assign in_ready_o  = ~rst_i & (count_q != FullCnt);
  assign out_valid_o = (count_q != '0);
  assign busy_o      = out_valid_o;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i;

  assign wr_entry = '{result: result_i, status: status_i, ext_bit: extension_bit_i, tag: tag_i};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    head = {$bits(output_t){DONT_CARE}};
    if (out_valid_o) head = mem_q[rd_ptr_q];
  end

  // A flush still retires the head if it is popped in that cycle.
  always_comb begin
    fflags_d = fflags_clr_i ? status_t'('0) : fflags_q;
    if (pop) fflags_d = fflags_d | head.status;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned with non-blocking <= so all flops update together.
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  // NOTE: the entry storage is not reset; out_valid_o masks stale contents.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign result_o        = head.result;
  assign status_o        = head.status;
  assign extension_bit_o = head.ext_bit;
  assign tag_o           = head.tag;
  assign fflags_o        = fflags_q;

endmodule

// File: tb/tb_fpnew_opgroup_out_buffer.sv
// Bench for the opgroup output buffer: Depth=2 and Depth=3 instances share the
// same stimulus and are each compared every cycle against a queue-based model.
module tb_fpnew_opgroup_out_buffer;

  typedef logic [3:0] tag_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  status;
    logic        ext;
    tag_t        tag;
  } ent_t;

  localparam int DEPTHS [2] = '{2, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, ext, flush, out_ready, fflags_clr;
  logic [31:0] result;
  logic [4:0]  status;
  tag_t        tag;

  fpnew_opgroup_out_buffer_if #(.Width(32), .TagType(tag_t)) bus0 ();
  fpnew_opgroup_out_buffer_if #(.Width(32), .TagType(tag_t)) bus1 ();

  assign bus0.in_valid   = in_valid;
  assign bus0.in_result  = result;
  assign bus0.in_status  = status;
  assign bus0.in_ext_bit = ext;
  assign bus0.in_tag     = tag;
  assign bus0.flush      = flush;
  assign bus0.out_ready  = out_ready;
  assign bus0.fflags_clr = fflags_clr;

  assign bus1.in_valid   = in_valid;
  assign bus1.in_result  = result;
  assign bus1.in_status  = status;
  assign bus1.in_ext_bit = ext;
  assign bus1.in_tag     = tag;
  assign bus1.flush      = flush;
  assign bus1.out_ready  = out_ready;
  assign bus1.fflags_clr = fflags_clr;

  fpnew_opgroup_out_buffer #(.Width(32), .Depth(2), .TagType(tag_t)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(bus0.in_valid), .in_ready_o(bus0.in_ready),
    .result_i(bus0.in_result), .status_i(bus0.in_status),
    .extension_bit_i(bus0.in_ext_bit), .tag_i(bus0.in_tag),
    .flush_i(bus0.flush),
    .out_valid_o(bus0.out_valid), .out_ready_i(bus0.out_ready),
    .result_o(bus0.out_result), .status_o(bus0.out_status),
    .extension_bit_o(bus0.out_ext_bit), .tag_o(bus0.out_tag),
    .fflags_o(bus0.fflags), .fflags_clr_i(bus0.fflags_clr),
    .busy_o(bus0.busy)
  );

  fpnew_opgroup_out_buffer #(.Width(32), .Depth(3), .TagType(tag_t)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(bus1.in_valid), .in_ready_o(bus1.in_ready),
    .result_i(bus1.in_result), .status_i(bus1.in_status),
    .extension_bit_i(bus1.in_ext_bit), .tag_i(bus1.in_tag),
    .flush_i(bus1.flush),
    .out_valid_o(bus1.out_valid), .out_ready_i(bus1.out_ready),
    .result_o(bus1.out_result), .status_o(bus1.out_status),
    .extension_bit_o(bus1.out_ext_bit), .tag_o(bus1.out_tag),
    .fflags_o(bus1.fflags), .fflags_clr_i(bus1.fflags_clr),
    .busy_o(bus1.busy)
  );

  logic        dut_in_ready [2];
  logic        dut_out_valid[2];
  logic        dut_busy     [2];
  logic        dut_ext      [2];
  logic [4:0]  dut_fflags   [2];
  logic [4:0]  dut_status   [2];
  logic [31:0] dut_result   [2];
  tag_t        dut_tag      [2];

  assign dut_in_ready[0]  = bus0.in_ready;
  assign dut_out_valid[0] = bus0.out_valid;
  assign dut_busy[0]      = bus0.busy;
  assign dut_ext[0]       = bus0.out_ext_bit;
  assign dut_fflags[0]    = bus0.fflags;
  assign dut_status[0]    = bus0.out_status;
  assign dut_result[0]    = bus0.out_result;
  assign dut_tag[0]       = bus0.out_tag;
  assign dut_in_ready[1]  = bus1.in_ready;
  assign dut_out_valid[1] = bus1.out_valid;
  assign dut_busy[1]      = bus1.busy;
  assign dut_ext[1]       = bus1.out_ext_bit;
  assign dut_fflags[1]    = bus1.fflags;
  assign dut_status[1]    = bus1.out_status;
  assign dut_result[1]    = bus1.out_result;
  assign dut_tag[1]       = bus1.out_tag;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: an ordered queue of held entries and a sticky flag word per instance.
  ent_t       mq [2][$];
  logic [4:0] m_fflags [2];
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    bit do_pop, do_push;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mq[k].delete();
        m_fflags[k] = 5'b0;
      end else begin
        do_pop  = (mq[k].size() > 0) && out_ready;
        do_push = in_valid && (mq[k].size() < DEPTHS[k]);
        if (fflags_clr) m_fflags[k] = 5'b0;
        if (do_pop) m_fflags[k] = m_fflags[k] | mq[k][0].status;
        if (flush) begin
          mq[k].delete();
        end else begin
          if (do_pop)  void'(mq[k].pop_front());
          if (do_push) mq[k].push_back({result, status, ext, tag});
        end
      end
    end
    if (rst) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d in_ready", k), dut_in_ready[k],
              (!rst && (mq[k].size() != DEPTHS[k])) ? 1'b1 : 1'b0);
        check($sformatf("dut%0d out_valid", k), dut_out_valid[k], (mq[k].size() > 0) ? 1'b1 : 1'b0);
        check($sformatf("dut%0d busy", k), dut_busy[k], (mq[k].size() > 0) ? 1'b1 : 1'b0);
        check($sformatf("dut%0d fflags", k), dut_fflags[k], m_fflags[k]);
        if (mq[k].size() > 0) begin
          check($sformatf("dut%0d result", k), dut_result[k], mq[k][0].result);
          check($sformatf("dut%0d status", k), dut_status[k], mq[k][0].status);
          check($sformatf("dut%0d ext", k), dut_ext[k], mq[k][0].ext);
          check($sformatf("dut%0d tag", k), dut_tag[k], mq[k][0].tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [31:0] r, input logic [4:0] s, input logic e, input tag_t t);
    in_valid = 1'b1;
    result   = r;
    status   = s;
    ext      = e;
    tag      = t;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ext = 1'b0; flush = 1'b0;
    out_ready = 1'b0; fflags_clr = 1'b0; result = '0; status = '0; tag = '0;
    step();
    check("in_ready low in reset", dut_in_ready[0], 1'b0);
    step();
    rst = 1'b0;
    step();
    check("idle in_ready", dut_in_ready[0], 1'b1);
    check("idle out_valid", dut_out_valid[0], 1'b0);
    check("idle busy", dut_busy[0], 1'b0);
    check("idle fflags", dut_fflags[0], 5'b0);

    // Fill the Depth=2 buffer with A then B while downstream stalls.
    put(32'h0000_00aa, 5'b00001, 1'b1, 4'd1);
    step();
    put(32'h0000_00bb, 5'b10000, 1'b0, 4'd2);
    step();
    in_valid = 1'b0;
    check("full in_ready", dut_in_ready[0], 1'b0);
    check("full out_valid", dut_out_valid[0], 1'b1);
    check("full head tag", dut_tag[0], 4'd1);
    check("full head result", dut_result[0], 32'h0000_00aa);

    // Pop while full with a push pending: only the pop happens this cycle.
    put(32'h0000_00cc, 5'b00100, 1'b1, 4'd3);
    out_ready = 1'b1;
    step();
    check("pop-only head tag", dut_tag[0], 4'd2);
    check("pop-only in_ready", dut_in_ready[0], 1'b1);
    check("pop-only fflags", dut_fflags[0], 5'b00001);
    step();
    check("push-next head tag", dut_tag[0], 4'd3);
    check("sticky fflags", dut_fflags[0], 5'b10001);
    check("model sticky fflags", m_fflags[0], 5'b10001);

    // Clear together with a pop leaves only the popped status.
    in_valid   = 1'b0;
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    out_ready  = 1'b0;
    check("clear+pop fflags", dut_fflags[0], 5'b00100);
    check("drained out_valid", dut_out_valid[0], 1'b0);
    check("drained busy", dut_busy[0], 1'b0);

    // Flush two held entries while a third is offered.
    put(32'h0000_00dd, 5'b01000, 1'b0, 4'd4);
    step();
    put(32'h0000_00ee, 5'b00010, 1'b1, 4'd5);
    step();
    put(32'h0000_00ff, 5'b00001, 1'b0, 4'd6);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", dut_out_valid[0], 1'b0);
    check("flush busy", dut_busy[0], 1'b0);
    check("flush in_ready", dut_in_ready[0], 1'b1);
    check("flush keeps fflags", dut_fflags[0], 5'b00100);
    put(32'h0000_0077, 5'b00000, 1'b1, 4'd7);
    step();
    in_valid = 1'b0;
    check("post-flush head tag", dut_tag[0], 4'd7);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;

    // Random traffic with flushes, clears and one mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      out_ready  = ($urandom_range(0, 99) < 50);
      result     = $urandom;
      status     = 5'($urandom_range(0, 31));
      ext        = 1'($urandom_range(0, 1));
      tag        = 4'($urandom_range(0, 15));
      flush      = ($urandom_range(0, 15) == 0);
      fflags_clr = ($urandom_range(0, 7) == 0);
      rst        = (i == 150);
      step();
      if (i == 150) begin
        check("mid reset in_ready", dut_in_ready[0], 1'b0);
        check("mid reset out_valid d2", dut_out_valid[0], 1'b0);
        check("mid reset out_valid d3", dut_out_valid[1], 1'b0);
        check("mid reset fflags d2", dut_fflags[0], 5'b0);
        check("mid reset fflags d3", dut_fflags[1], 5'b0);
      end
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; fflags_clr = 1'b0; out_ready = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
